serial_alu_ctrl: RTL and testbench
==================================

// Module: serial_alu_ctrl
// PURPOSE
//  Sequencer that runs a wide add/subtract through one 4-bit add/sub slice, one nibble per cycle, LSB first.
//  Captures operands via valid/ready, chains carry between nibbles, returns result and flags via valid/ready.
//  Sits between the control path and the 4-bit ALU datapath; it is the only master of the nibble slice.
// PARAMETERS
//  NIBBLES  4  number of 4-bit slices; operand width W = 4*NIBBLES (must be >= 2)
// PORTS
//  clk         in   1    single system clock, all state on rising edge
//  rst_n       in   1    synchronous reset, active-low
//  start_valid in   1    request carries valid op_a/op_b/op_sub
//  start_ready out  1    block can accept a request (IDLE only)
//  op_a        in   W    operand A
//  op_b        in   W    operand B
//  op_sub      in   1    0 = A+B, 1 = A-B (two's complement: A + ~B + 1)
//  res_valid   out  1    result/flags valid; held until accepted
//  res_ready   in   1    consumer accepts result
//  result      out  W    sum/difference, modulo 2^W
//  cero        out  1    result == 0
//  negativo    out  1    result[W-1] & op_sub (subtraction only)
//  c_out       out  1    carry out of MSB nibble (subtract: 1 = no borrow)
//  overflow    out  1    carry into MSB ^ carry out of MSB
//  busy        out  1    state != IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE; result, all flags, res_valid, idx, carry cleared to 0.
//  States: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: start_ready=1. start_valid=1 at edge: latch op_a, op_b, op_sub; idx=0; carry=op_sub; -> RUN.
//  RUN: each cycle slice idx computes a[idx] + (b[idx]^{4{op_sub}}) + carry; nibble written to result[idx],
//    carry <= slice cout. On idx==NIBBLES-1: latch c_out=cout, overflow=cout^c3 (carry into bit 3),
//    compute cero/negativo from the completed result; -> DONE. Else idx++.
//  Latency: res_valid rises exactly NIBBLES edges after the accepting edge.
//  DONE: res_valid=1; result/flags stable. res_ready=1 at edge -> IDLE, res_valid=0.
//  start_ready=0 outside IDLE; no same-cycle retire+accept (one idle cycle between ops, minimum).
//  Input ports ignored outside IDLE; latched copies only are used.
//  Outputs retain last values in IDLE until the next op overwrites them nibble by nibble.
//  Reset mid-RUN or mid-DONE: abandons op, returns to IDLE with reset values next cycle; no res_valid.
//  Wrap: results are modulo 2^W; no saturation.
// CONFIGURATION
//  SERIAL_ALU_ABORT_EN defined: extra port abort (in, 1). abort=1 at edge in RUN or DONE -> IDLE,
//    res_valid=0, flags cleared; abort in IDLE ignored; abort has priority over res_ready and last-nibble completion.
//  Not defined: no abort port; an op always runs to DONE and waits for res_ready.
// STRUCTURE
//  Package serial_alu_pkg: NIBBLE_W=4; typedef enum logic [1:0] {IDLE, RUN, DONE} state_t.
//  Sub-module nibble_addsub: 4-bit a, b, sub, cin -> sum[3:0], cout, c3 (carry into bit 3); combinational.
//  Top holds FSM, idx counter ($clog2(NIBBLES) bits), carry reg, operand/result registers.
// TESTING (NIBBLES=4)
//  0x1234 + 0x0FFF -> 0x2233 after 4 cycles; cero=0 negativo=0 c_out=0 overflow=0.
//  0x0005 - 0x0005 -> 0x0000; cero=1 negativo=0 c_out=1 overflow=0.
//  0x0003 - 0x0005 -> 0xFFFE; negativo=1 c_out=0 overflow=0.
//  0x7FFF + 0x0001 -> 0x8000 overflow=1 negativo=0; 0xFFFF + 0x0001 -> 0x0000 c_out=1 cero=1.
//  res_ready held 0 for 10 cycles: res_valid, result, flags stable; start_ready=0 throughout.
//  rst_n=0 at RUN idx=2: next cycle IDLE, res_valid=0, outputs 0; with SERIAL_ALU_ABORT_EN, abort at idx=1 gives same.

Source files
------------

// File: rtl/serial_alu_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package serial_alu_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/serial_alu_nibble_addsub.sv
// One 4-bit add/subtract slice. Subtraction inverts b; the caller supplies
// the +1 through cin on the first nibble. c3 is the carry into bit 3, used
// by the sequencer to form signed overflow on the most significant nibble.
module nibble_addsub import serial_alu_pkg::*; (
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                sub,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout,
  output logic                c3
);
  logic [NIBBLE_W-1:0] b_eff;
  logic [NIBBLE_W-1:0] lo;
  logic [1:0]          hi;

  assign b_eff = b ^ {NIBBLE_W{sub}};
  // Low three bits first so the carry into the top bit is visible.
  assign lo    = {1'b0, a[2:0]} + {1'b0, b_eff[2:0]} + {3'b000, cin};
  assign hi    = {1'b0, a[3]} + {1'b0, b_eff[3]} + {1'b0, lo[3]};
  assign sum   = {hi[0], lo[2:0]};
  assign cout  = hi[1];
  assign c3    = lo[3];
endmodule

// File: rtl/serial_alu_ctrl.sv
// Sequencer that pushes a W-bit add/subtract through a single nibble slice,
// LSB nibble first, and hands back result plus flags over valid/ready.
// Optional: define SERIAL_ALU_ABORT_EN to add an abort input that cancels
// an in-flight or unretired operation.
module serial_alu_ctrl import serial_alu_pkg::*; #(
  parameter  int NIBBLES = 4,
  localparam int W       = NIBBLE_W * NIBBLES,
  localparam int IW      = $clog2(NIBBLES)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         op_sub,
  output logic         res_valid,
  input  logic         res_ready,
`ifdef SERIAL_ALU_ABORT_EN
  input  logic         abort,
`endif
  output logic [W-1:0] result,
  output logic         cero,
  output logic         negativo,
  output logic         c_out,
  output logic         overflow,
  output logic         busy
);
  state_t state;
  logic [IW-1:0] idx;
  logic          carry;
  logic          sub_q;
  logic [NIBBLES-1:0][NIBBLE_W-1:0] a_q, b_q, res_q, done_res;
  logic [NIBBLE_W-1:0] nib_sum;
  logic nib_cout, nib_c3, last;

  nibble_addsub u_slice (
    .a   (a_q[idx]),
    .b   (b_q[idx]),
    .sub (sub_q),
    .cin (carry),
    .sum (nib_sum),
    .cout(nib_cout),
    .c3  (nib_c3)
  );

  assign last        = (idx == IW'(NIBBLES - 1));
  assign result      = res_q;
  assign start_ready = (state == IDLE);
  assign busy        = (state != IDLE);

  // Result as it will look once the final nibble lands; feeds the zero flag.
  always_comb begin
    done_res            = res_q;
    done_res[NIBBLES-1] = nib_sum;
  end

  // FSM, operand capture, nibble write-back and flag latching.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      sub_q     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      res_valid <= 1'b0;
      cero      <= 1'b0;
      negativo  <= 1'b0;
      c_out     <= 1'b0;
      overflow  <= 1'b0;
    end
`ifdef SERIAL_ALU_ABORT_EN
    // Abort outranks both retirement and last-nibble completion.
    else if (abort && state != IDLE) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      res_q     <= '0;
      res_valid <= 1'b0;
      cero      <= 1'b0;
      negativo  <= 1'b0;
      c_out     <= 1'b0;
      overflow  <= 1'b0;
    end
`endif
    else begin
      case (state)
        IDLE: if (start_valid) begin
          a_q   <= op_a;
          b_q   <= op_b;
          sub_q <= op_sub;
          idx   <= '0;
          carry <= op_sub;
          state <= RUN;
        end
        RUN: begin
          res_q[idx] <= nib_sum;
          carry      <= nib_cout;
          if (last) begin
            c_out     <= nib_cout;
            overflow  <= nib_cout ^ nib_c3;
            cero      <= (done_res == '0);
            negativo  <= nib_sum[NIBBLE_W-1] & sub_q;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: if (res_ready) begin
          res_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Scoreboard bench for serial_alu_ctrl: a driver pushes expected responses
// from an arithmetic reference model, a monitor pops them on each handshake.
module tb_serial_alu_ctrl;
  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start_valid = 1'b0, op_sub = 1'b0, res_ready = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic start_ready, res_valid, cero, negativo, c_out, overflow, busy;
  logic [W-1:0] result;
`ifdef SERIAL_ALU_ABORT_EN
  logic abort = 1'b0;
`endif

  serial_alu_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .op_a(op_a), .op_b(op_b), .op_sub(op_sub),
    .res_valid(res_valid), .res_ready(res_ready),
`ifdef SERIAL_ALU_ABORT_EN
    .abort(abort),
`endif
    .result(result), .cero(cero), .negativo(negativo),
    .c_out(c_out), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] r;
    logic z, n, c, v;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int n_cmp = 0, n_fail = 0;
  bit hold_rr = 1'b0;

  // Reference: plain integer arithmetic on the whole word.
  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic sub);
    exp_t e;
    int sa, sbv, s;
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    if (sub) begin
      e.r = a - b;
      e.c = (a >= b);
      s   = sa - sbv;
    end else begin
      e.r = a + b;
      e.c = ((int'(a) + int'(b)) >= (1 << W));
      s   = sa + sbv;
    end
    e.v = (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
    e.z = (e.r == '0);
    e.n = e.r[W-1] & sub;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_exp(input string nm, input exp_t e);
    chk({nm, ".result"},   32'(result),   32'(e.r));
    chk({nm, ".cero"},     32'(cero),     32'(e.z));
    chk({nm, ".negativo"}, 32'(negativo), 32'(e.n));
    chk({nm, ".c_out"},    32'(c_out),    32'(e.c));
    chk({nm, ".overflow"}, 32'(overflow), 32'(e.v));
  endtask

  // Consumer: res_ready changes just after a rising edge, stable by the negedge.
  initial forever begin
    @(posedge clk); #1;
    res_ready = hold_rr ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: a handshake will occur on the coming edge; check it against the queue.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_result: got %0h with no expectation queued", result);
      end else begin
        mon_e = sb.pop_front();
        chk_exp("resp", mon_e);
      end
    end
  end

  // Present one request and return #1 after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input bit push);
    int t = 0;
    @(negedge clk);
    while (!start_ready && t < 50) begin @(negedge clk); t++; end
    if (!start_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL start_timeout: got start_ready=0 required 1");
    end
    op_a = a; op_b = b; op_sub = sub; start_valid = 1'b1;
    if (push) sb.push_back(model(a, b, sub));
    @(posedge clk); #1;
    start_valid = 1'b0;
    // Scramble the inputs: the DUT must use its latched copies.
    op_a = W'($urandom); op_b = W'($urandom); op_sub = 1'($urandom);
  endtask

  // res_valid must rise exactly NIBBLES edges after acceptance.
  task automatic check_latency();
    repeat (NIBBLES - 1) @(posedge clk);
    #1 chk("latency_early", 32'(res_valid), 32'd0);
    @(posedge clk);
    #1 chk("latency_rise", 32'(res_valid), 32'd1);
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || busy) && t < 200) begin @(negedge clk); t++; end
    if (sb.size() != 0 || busy) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: got %0d pending required 0", sb.size());
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    issue(a, b, sub, 1'b1);
    check_latency();
    drain();
  endtask

  task automatic check_cleared(input string nm);
    chk({nm, ".res_valid"},   32'(res_valid),   32'd0);
    chk({nm, ".busy"},        32'(busy),        32'd0);
    chk({nm, ".start_ready"}, 32'(start_ready), 32'd1);
    chk({nm, ".result"},      32'(result),      32'd0);
    chk({nm, ".flags"}, 32'({cero, negativo, c_out, overflow}), 32'd0);
  endtask

  logic [W-1:0] ra, rb;
  exp_t es;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1 check_cleared("reset");
    rst_n = 1'b1;

    // Directed cases
    run_op(16'h1234, 16'h0FFF, 1'b0);
    run_op(16'h0005, 16'h0005, 1'b1);
    run_op(16'h0003, 16'h0005, 1'b1);
    run_op(16'h7FFF, 16'h0001, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1);
    run_op(16'h0000, 16'h0000, 1'b0);

    // Back-pressure: result held steady for 10 cycles with res_ready low
    hold_rr = 1'b1;
    @(posedge clk); #2;
    es = model(16'hA5C3, 16'h5A3C, 1'b1);
    issue(16'hA5C3, 16'h5A3C, 1'b1, 1'b1);
    check_latency();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall.res_valid", 32'(res_valid), 32'd1);
      chk("stall.start_ready", 32'(start_ready), 32'd0);
      chk_exp("stall", es);
    end
    hold_rr = 1'b0;
    drain();

    // Reset in RUN at idx=2 abandons the op
    run_op(16'h0003, 16'h0005, 1'b1);
    issue(16'h1111, 16'h2222, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 check_cleared("rst_mid_run");
    rst_n = 1'b1;

`ifdef SERIAL_ALU_ABORT_EN
    // Abort in RUN at idx=1 behaves like reset
    run_op(16'h0003, 16'h0005, 1'b1);
    issue(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check_cleared("abort_mid_run");
`endif

    // Randomized operations with a bias toward boundary operands
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: begin ra = W'($urandom); rb = W'($urandom); end
        1: begin ra = W'($urandom); rb = ra; end
        2: begin ra = 16'h7FFF; rb = W'($urandom_range(0, 3)); end
        default: begin ra = 16'h8000 - W'($urandom_range(0, 2)); rb = 16'hFFFF; end
      endcase
      run_op(ra, rb, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_cmp++; n_fail++;
    $display("FAIL watchdog: got no completion required finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
